fp_argmax_seq: RTL and testbench

//   Streaming max/argmax reducer for FloPoCo-format floats. It sequences one shared fcmplt

---
 rtl/fp_cmp_pkg.sv | 14 +
 rtl/fcmplt.sv | 27 ++
 rtl/fp_argmax_seq.sv | 82 ++++++++
 tb/tb_fp_argmax_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fp_cmp_pkg.sv
// fp_cmp_pkg: shared FloPoCo float constants, NaN test and argmax FSM state type.
package fp_cmp_pkg;
    localparam int FP_WE = 5;
    localparam int FP_WF = 5;
    localparam int FP_W  = FP_WE + FP_WF + 3;
    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;
    typedef enum logic [1:0] {S_FIRST, S_ACC, S_OUT} state_t;
    function automatic logic is_nan(input logic [FP_W-1:0] x);
        return x[FP_W-1:FP_W-2] == EXC_NAN;
    endfunction
endpackage

// File: rtl/fcmplt.sv
// fcmplt: combinational FloPoCo less-than; NaN on either side is unordered and never less-than.
module fcmplt
    import fp_cmp_pkg::*;
#(
    parameter int WE = 5,
    parameter int WF = 5
) (
    input  logic [WE+WF+2:0] i_x,
    input  logic [WE+WF+2:0] i_y,
    output logic             o_xlty,
    output logic             o_unordered
);
    localparam int W = WE + WF + 3;
    logic [W-2:0] w_mx, w_my;
    logic         w_sx, w_sy;
    // Zeros collapse to 0 and infinities to one key so -0==+0 and inf payloads don't matter.
    assign w_mx = i_x[W-1:W-2] == EXC_ZERO ? '0 :
                  i_x[W-1:W-2] == EXC_INF  ? {EXC_INF, {(WE+WF){1'b0}}} :
                  {i_x[W-1:W-2], i_x[WE+WF-1:0]};
    assign w_my = i_y[W-1:W-2] == EXC_ZERO ? '0 :
                  i_y[W-1:W-2] == EXC_INF  ? {EXC_INF, {(WE+WF){1'b0}}} :
                  {i_y[W-1:W-2], i_y[WE+WF-1:0]};
    assign w_sx = i_x[W-3] & |w_mx;
    assign w_sy = i_y[W-3] & |w_my;
    assign o_unordered = (i_x[W-1:W-2] == EXC_NAN) | (i_y[W-1:W-2] == EXC_NAN);
    assign o_xlty = ~o_unordered & (w_sx != w_sy ? w_sx : w_sx ? (w_my < w_mx) : (w_mx < w_my));
endmodule

// File: rtl/fp_argmax_seq.sv
// fp_argmax_seq: streaming max/argmax over a vector, one element per cycle,
// time-sharing a single fcmplt comparator.
module fp_argmax_seq
    import fp_cmp_pkg::*;
#(
    parameter int WE    = 5,
    parameter int WF    = 5,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [WE+WF+2:0]   i_in_data,
    input  logic               i_in_last,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [WE+WF+2:0]   o_out_max,
    output logic [LEN_W-1:0]   o_out_idx,
    output logic [LEN_W:0]     o_out_count,
    output logic               o_out_unordered
);
    localparam int W = WE + WF + 3;
    if (WE != FP_WE || WF != FP_WF) begin : g_bad_core
        $error("fp_argmax_seq: WE/WF must match the fcmplt core (5/5)");
    end
    state_t           r_state, w_next;
    logic [W-1:0]     r_max;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W:0]   r_count;
    logic             r_unord;
    logic             w_accept, w_end, w_take, w_nan_in, w_lt, w_cmp_unord;
    logic [LEN_W-1:0] w_cur_idx;
    fcmplt #(.WE(WE), .WF(WF)) u_cmp (
        .i_x         (r_max),
        .i_y         (i_in_data),
        .o_xlty      (w_lt),
        .o_unordered (w_cmp_unord)
    );
    assign w_accept  = i_in_valid & o_in_ready;
    assign w_nan_in  = is_nan(i_in_data);
    assign w_cur_idx = r_state == S_FIRST ? '0 : r_count[LEN_W-1:0];
    // The last representable index closes the vector even without in_last, so count never wraps.
    assign w_end     = i_in_last | (&w_cur_idx);
    assign w_take    = (r_state == S_FIRST) | (is_nan(r_max) & ~w_nan_in) | (w_lt & ~w_cmp_unord);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FIRST;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FIRST: w_next = w_accept ? (w_end ? S_OUT : S_ACC) : S_FIRST;
            S_ACC:   w_next = (w_accept && w_end) ? S_OUT : S_ACC;
            S_OUT:   w_next = i_out_ready ? S_FIRST : S_OUT;
            default: w_next = S_FIRST;
        endcase
    end
    always_comb begin
        o_in_ready  = r_state != S_OUT;
        o_out_valid = r_state == S_OUT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max   <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_unord <= 1'b0;
        end else if (w_accept) begin
            if (w_take) begin
                r_max <= i_in_data;
                r_idx <= w_cur_idx;
            end
            r_count <= {1'b0, w_cur_idx} + {{LEN_W{1'b0}}, 1'b1};
            r_unord <= (r_unord & (r_state != S_FIRST)) | w_nan_in;
        end
    end
    assign o_out_max       = r_max;
    assign o_out_idx       = r_idx;
    assign o_out_count     = r_count;
    assign o_out_unordered = r_unord;
endmodule

// File: tb/tb_fp_argmax_seq.sv
// tb_fp_argmax_seq: directed vectors with hand-computed max/idx/count/unordered results.
module tb_fp_argmax_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_iv = 1'b0, a_last = 1'b0, a_ordy = 1'b0;
    logic [12:0] a_data = '0;
    logic        a_ir, a_ov, a_unord;
    logic [12:0] a_max;
    logic [7:0]  a_idx;
    logic [8:0]  a_cnt;
    logic        b_iv = 1'b0, b_last = 1'b0, b_ordy = 1'b0;
    logic [12:0] b_data = '0;
    logic        b_ir, b_ov, b_unord;
    logic [12:0] b_max;
    logic [1:0]  b_idx;
    logic [2:0]  b_cnt;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_argmax_seq #(.WE(5), .WF(5), .LEN_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_in_valid(a_iv), .o_in_ready(a_ir), .i_in_data(a_data),
        .i_in_last(a_last), .o_out_valid(a_ov), .i_out_ready(a_ordy), .o_out_max(a_max),
        .o_out_idx(a_idx), .o_out_count(a_cnt), .o_out_unordered(a_unord));

    fp_argmax_seq #(.WE(5), .WF(5), .LEN_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_in_valid(b_iv), .o_in_ready(b_ir), .i_in_data(b_data),
        .i_in_last(b_last), .o_out_valid(b_ov), .i_out_ready(b_ordy), .o_out_max(b_max),
        .o_out_idx(b_idx), .o_out_count(b_cnt), .o_out_unordered(b_unord));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_a(input logic [12:0] d, input logic last);
        a_iv = 1'b1; a_data = d; a_last = last;
        chk("a_in_ready", 32'(a_ir), 1);
        @(posedge clk); #1;
        a_iv = 1'b0; a_last = 1'b0;
    endtask

    task automatic push_b(input logic [12:0] d, input logic last);
        b_iv = 1'b1; b_data = d; b_last = last;
        chk("b_in_ready", 32'(b_ir), 1);
        @(posedge clk); #1;
        b_iv = 1'b0; b_last = 1'b0;
    endtask

    task automatic expect_a(input logic [12:0] m, input logic [7:0] ix, input logic [8:0] c, input logic u);
        chk("a_out_valid", 32'(a_ov), 1);
        chk("a_out_max", 32'(a_max), 32'(m));
        chk("a_out_idx", 32'(a_idx), 32'(ix));
        chk("a_out_count", 32'(a_cnt), 32'(c));
        chk("a_out_unord", 32'(a_unord), 32'(u));
        a_ordy = 1'b1;
        chk("a_in_ready_at_hs", 32'(a_ir), 0);
        @(posedge clk); #1;
        a_ordy = 1'b0;
        chk("a_valid_after_hs", 32'(a_ov), 0);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", 32'(a_ir), 1);
        chk("rst_out_valid", 32'(a_ov), 0);
        chk("rst_max", 32'(a_max), 0);
        chk("rst_idx", 32'(a_idx), 0);
        chk("rst_count", 32'(a_cnt), 0);
        chk("rst_unord", 32'(a_unord), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        // basic: 1, -3, 2, 1
        push_a(13'h09E0, 0); push_a(13'h0E10, 0); push_a(13'h0A00, 0);
        chk("basic_no_early_valid", 32'(a_ov), 0);
        push_a(13'h09E0, 1);
        expect_a(13'h0A00, 2, 4, 0);
        // ties keep the first
        push_a(13'h0A00, 0); push_a(13'h0A00, 1);
        expect_a(13'h0A00, 0, 2, 0);
        push_a(13'h0400, 0); push_a(13'h0000, 1);
        expect_a(13'h0400, 0, 2, 0);
        // negatives and zero below a later positive
        push_a(13'h0E10, 0); push_a(13'h0400, 0); push_a(13'h09E0, 1);
        expect_a(13'h09E0, 2, 3, 0);
        // NaN handling
        push_a(13'h1800, 0); push_a(13'h09E0, 0); push_a(13'h1000, 1);
        expect_a(13'h1000, 2, 3, 1);
        push_a(13'h1800, 1);
        expect_a(13'h1800, 0, 1, 1);
        // backpressure with upstream holding a pending element
        push_a(13'h09E0, 0); push_a(13'h0A00, 1);
        a_iv = 1'b1; a_data = 13'h1000; a_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(a_ov), 1);
            chk("bp_in_ready", 32'(a_ir), 0);
            chk("bp_max", 32'(a_max), 32'h0A00);
            chk("bp_idx", 32'(a_idx), 1);
            chk("bp_count", 32'(a_cnt), 2);
        end
        a_ordy = 1'b1;
        chk("bp_in_ready_hs", 32'(a_ir), 0);
        @(posedge clk); #1;
        a_ordy = 1'b0; a_iv = 1'b0; a_last = 1'b0;
        chk("bp_valid_after_hs", 32'(a_ov), 0);
        push_a(13'h09E0, 1);
        expect_a(13'h09E0, 0, 1, 0);
        // implicit last at index 3 with LEN_W=2
        push_b(13'h09E0, 0); push_b(13'h0A00, 0); push_b(13'h0E10, 0);
        chk("b_no_early_valid", 32'(b_ov), 0);
        push_b(13'h09E0, 0);
        chk("b_out_valid", 32'(b_ov), 1);
        chk("b_out_max", 32'(b_max), 32'h0A00);
        chk("b_out_idx", 32'(b_idx), 1);
        chk("b_out_count", 32'(b_cnt), 4);
        chk("b_out_unord", 32'(b_unord), 0);
        b_ordy = 1'b1;
        @(posedge clk); #1;
        b_ordy = 1'b0;
        push_b(13'h1000, 1);
        chk("b2_out_valid", 32'(b_ov), 1);
        chk("b2_out_max", 32'(b_max), 32'h1000);
        chk("b2_out_idx", 32'(b_idx), 0);
        chk("b2_out_count", 32'(b_cnt), 1);
        b_ordy = 1'b1;
        @(posedge clk); #1;
        b_ordy = 1'b0;
        // reset mid-vector discards the partial vector
        push_a(13'h0A00, 0); push_a(13'h0A00, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(a_ov), 0);
        chk("mid_rst_in_ready", 32'(a_ir), 1);
        chk("mid_rst_count", 32'(a_cnt), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(a_ov), 0);
        push_a(13'h09E0, 1);
        expect_a(13'h09E0, 0, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
